// File: rtl/cavity_drive_seq_pkg.sv
// Shared definitions for the cavity drive sequencer: default widths, the
// saturation-limit helper, FSM state encodings and the registered status word.
package cavity_drive_seq_pkg;

  localparam int unsigned DW_DEF = 16;
  localparam int unsigned CW_DEF = 20;
  localparam int unsigned SW_DEF = 12;

  // Largest positive signed value of width w (32767 for w=16).
  function automatic int sat_limit(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  // TRIP lives above the 2-bit externally visible codes.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RAMP  = 3'd1,
    S_FLAT  = 3'd2,
    S_DECAY = 3'd3,
    S_TRIP  = 3'd4
  } state_t;

  typedef struct packed {
    logic       busy;
    logic       tripped;
    logic [1:0] code;
  } stat_t;

  // Status outputs that accompany a given state.
  function automatic stat_t stat_of(input state_t s);
    stat_t r;
    r.busy    = (s == S_RAMP) || (s == S_FLAT) || (s == S_DECAY);
    r.tripped = (s == S_TRIP);
    r.code    = (s == S_TRIP) ? 2'd0 : 2'(s);
    return r;
  endfunction

endpackage

// File: rtl/cavity_drive_seq_sat_abs.sv
// sat_abs: saturating absolute value of a signed sample.
// Ports: i_x (signed, dw bits) -> o_abs_c (unsigned, dw-1 bits, combinational).
// The most negative input saturates to the largest positive value.
module sat_abs
  import cavity_drive_seq_pkg::*;
#(
  parameter int unsigned dw = DW_DEF
) (
  input  logic signed [dw-1:0] i_x,
  output logic        [dw-2:0] o_abs_c
);

  localparam int LIM = sat_limit(dw);

  logic signed [dw-1:0] w_neg;

  assign w_neg = -i_x;

  always_comb begin
    o_abs_c = i_x[dw-2:0];
    if (i_x[dw-1]) begin
      // Only the most negative value stays negative after negation.
      if (w_neg[dw-1]) o_abs_c = (dw-1)'(LIM);
      else             o_abs_c = w_neg[dw-2:0];
    end
  end

endmodule

// File: rtl/cavity_drive_seq.sv
// cavity_drive_seq: trigger-started pulse sequencer for the cavity drive.
// Ramps to a latched amplitude, holds a flat-top, ramps back to zero, and
// hard-trips the drive to zero when |cav| exceeds trip_level.
// Ports: clk, rst (sync, active-high); trig, abort, trip_clear controls;
// amp/step/flat_len pulse settings; trip_level threshold; cav response;
// drive (registered signed), busy, tripped, state (2-bit code).
module cavity_drive_seq
  import cavity_drive_seq_pkg::*;
#(
  parameter int unsigned dw = DW_DEF,
  parameter int unsigned cw = CW_DEF,
  parameter int unsigned sw = SW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trig,
  input  logic                 abort,
  input  logic signed [dw-1:0] amp,
  input  logic        [sw-1:0] step,
  input  logic        [cw-1:0] flat_len,
  input  logic        [dw-2:0] trip_level,
  input  logic                 trip_clear,
  input  logic signed [dw-1:0] cav,
  output logic signed [dw-1:0] drive,
  output logic                 busy,
  output logic                 tripped,
  output logic        [1:0]    state
);

  localparam int                   LIM     = sat_limit(dw);
  localparam logic signed [dw-1:0] LIM_P   = dw'(LIM);
  localparam logic signed [dw-1:0] LIM_N   = -LIM_P;
  localparam logic signed [dw-1:0] MIN_V   = {1'b1, {(dw-1){1'b0}}};
  localparam logic signed [dw:0]   LIM17_P = {LIM_P[dw-1], LIM_P};
  localparam logic signed [dw:0]   LIM17_N = -LIM17_P;

  state_t               r_state;
  stat_t                r_stat;
  logic signed [dw-1:0] r_drive;
  logic signed [dw-1:0] r_amp;
  logic        [sw-1:0] r_step;
  logic        [cw-1:0] r_flat;
  logic        [cw-1:0] r_cnt;
  logic                 r_trip_hit;

  logic signed [dw-1:0] w_amp_in;
  logic signed [dw-1:0] w_first;
  logic signed [dw-1:0] w_ramp;
  logic signed [dw-1:0] w_decay;
  logic        [dw-2:0] w_cav_abs;

  // One step from cur toward tgt with a one-bit-wider intermediate,
  // saturated to the symmetric range and clamped so tgt is never passed.
  function automatic logic signed [dw-1:0] toward(
    input logic signed [dw-1:0] cur,
    input logic signed [dw-1:0] tgt,
    input logic        [sw-1:0] stp
  );
    logic signed [dw:0]   c_x;
    logic signed [dw:0]   t_x;
    logic signed [dw:0]   s_x;
    logic signed [dw:0]   sum;
    logic signed [dw-1:0] res;
    c_x = {cur[dw-1], cur};
    t_x = {tgt[dw-1], tgt};
    s_x = {{(dw+1-sw){1'b0}}, stp};
    res = tgt;
    if (stp != '0) begin
      if (t_x > c_x) begin
        sum = c_x + s_x;
        if (sum > LIM17_P) sum = LIM17_P;
        if (sum < t_x) res = sum[dw-1:0];
      end else begin
        sum = c_x - s_x;
        if (sum < LIM17_N) sum = LIM17_N;
        if (sum > t_x) res = sum[dw-1:0];
      end
    end
    return res;
  endfunction

  sat_abs #(.dw(dw)) u_cav_abs (
    .i_x     (cav),
    .o_abs_c (w_cav_abs)
  );

  // Keep the amplitude range symmetric so |drive| never exceeds LIM.
  assign w_amp_in = (amp == MIN_V) ? LIM_N : amp;
  assign w_first  = toward('0, w_amp_in, step);
  assign w_ramp   = toward(r_drive, r_amp, r_step);
  assign w_decay  = toward(r_drive, '0, r_step);

  assign drive   = r_drive;
  assign busy    = r_stat.busy;
  assign tripped = r_stat.tripped;
  assign state   = r_stat.code;

  // Sequencer: drive and status are updated together so they always align.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_stat     <= stat_of(S_IDLE);
      r_drive    <= '0;
      r_amp      <= '0;
      r_step     <= '0;
      r_flat     <= '0;
      r_cnt      <= '0;
      r_trip_hit <= 1'b0;
    end else begin
      r_trip_hit <= (w_cav_abs > trip_level);
      if (r_trip_hit && (r_state != S_TRIP)) begin
        r_state <= S_TRIP;
        r_stat  <= stat_of(S_TRIP);
        r_drive <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_drive <= '0;
            if (trig) begin
              r_amp   <= w_amp_in;
              r_step  <= step;
              r_flat  <= flat_len;
              r_cnt   <= '0;
              r_drive <= w_first;
              r_state <= S_RAMP;
              r_stat  <= stat_of(S_RAMP);
            end
          end
          S_RAMP: begin
            if (abort || ((r_drive == r_amp) && (r_flat == '0))) begin
              r_drive <= w_decay;
              r_state <= S_DECAY;
              r_stat  <= stat_of(S_DECAY);
            end else if (r_drive == r_amp) begin
              r_cnt   <= cw'(1);
              r_state <= S_FLAT;
              r_stat  <= stat_of(S_FLAT);
            end else begin
              r_drive <= w_ramp;
            end
          end
          S_FLAT: begin
            if (abort || (r_cnt == r_flat)) begin
              r_drive <= w_decay;
              r_state <= S_DECAY;
              r_stat  <= stat_of(S_DECAY);
            end else begin
              r_cnt <= r_cnt + cw'(1);
            end
          end
          S_DECAY: begin
            if (r_drive == '0) begin
              r_state <= S_IDLE;
              r_stat  <= stat_of(S_IDLE);
            end else begin
              r_drive <= w_decay;
            end
          end
          S_TRIP: begin
            r_drive <= '0;
            if (trip_clear && !r_trip_hit) begin
              r_state <= S_IDLE;
              r_stat  <= stat_of(S_IDLE);
            end
          end
          default: begin
            r_drive <= '0;
            r_state <= S_IDLE;
            r_stat  <= stat_of(S_IDLE);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cavity_drive_seq.sv
// Scoreboard bench for cavity_drive_seq: the stimulus thread pushes the
// expected per-cycle outputs, the monitor thread pops one entry per clock.
module tb_cavity_drive_seq;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RAMP  = 2'd1;
  localparam logic [1:0] ST_FLAT  = 2'd2;
  localparam logic [1:0] ST_DECAY = 2'd3;

  logic               clk;
  logic               rst;
  logic               trig;
  logic               abort;
  logic signed [15:0] amp;
  logic        [11:0] step;
  logic        [19:0] flat_len;
  logic        [14:0] trip_level;
  logic               trip_clear;
  logic signed [15:0] cav;
  logic signed [15:0] drive;
  logic               busy;
  logic               tripped;
  logic        [1:0]  state;

  typedef struct {
    int         drv;
    logic [1:0] st;
    logic       bsy;
    logic       trp;
    string      tag;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_tests;
  int   n_fail;

  cavity_drive_seq dut (
    .clk        (clk),
    .rst        (rst),
    .trig       (trig),
    .abort      (abort),
    .amp        (amp),
    .step       (step),
    .flat_len   (flat_len),
    .trip_level (trip_level),
    .trip_clear (trip_clear),
    .cav        (cav),
    .drive      (drive),
    .busy       (busy),
    .tripped    (tripped),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input int d, input logic [1:0] st, input logic b,
                      input logic t, input string tag);
    exp_t e;
    e.drv = d;
    e.st  = st;
    e.bsy = b;
    e.trp = t;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic ex_i(input string tag);        push(0, ST_IDLE,  1'b0, 1'b0, tag); endtask
  task automatic ex_r(input int d, input string tag); push(d, ST_RAMP,  1'b1, 1'b0, tag); endtask
  task automatic ex_f(input int d, input string tag); push(d, ST_FLAT,  1'b1, 1'b0, tag); endtask
  task automatic ex_d(input int d, input string tag); push(d, ST_DECAY, 1'b1, 1'b0, tag); endtask
  task automatic ex_t(input string tag);        push(0, ST_IDLE,  1'b0, 1'b1, tag); endtask

  // Wait (bounded) until every pushed expectation has been checked.
  task automatic drain(input string tag);
    int c;
    c = 0;
    while (q.size() != 0 && c < 400) begin
      @(negedge clk);
      c++;
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard still holds %0d entries, required 0", tag, q.size());
      q.delete();
    end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    trig       = 1'b0;
    abort      = 1'b0;
    amp        = 16'sd0;
    step       = 12'd0;
    flat_len   = 20'd0;
    trip_level = 15'd32767;
    trip_clear = 1'b0;
    cav        = 16'sd0;
    fork
      // Monitor: one expectation per clock while any are queued.
      forever begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
          m_e = q.pop_front();
          n_tests++;
          if (drive !== 16'(m_e.drv) || state !== m_e.st ||
              busy !== m_e.bsy || tripped !== m_e.trp) begin
            n_fail++;
            $display("FAIL %s: got drive=%0d state=%0d busy=%0b tripped=%0b, expected drive=%0d state=%0d busy=%0b tripped=%0b",
                     m_e.tag, drive, state, busy, tripped, m_e.drv, m_e.st, m_e.bsy, m_e.trp);
          end
        end
      end
      begin
        // Reset state
        @(negedge clk);
        ex_i("reset");
        ex_i("reset");
        drain("reset");
        rst = 1'b0;
        ex_i("idle_after_reset");
        drain("idle_after_reset");

        // 1: nominal pulse; inputs changed after trig must not matter
        amp = 16'sd1000; step = 12'd100; flat_len = 20'd5; trig = 1'b1;
        for (int i = 1; i <= 10; i++) ex_r(100 * i, "t1_ramp");
        for (int i = 0; i < 5; i++)   ex_f(1000, "t1_flat");
        for (int i = 9; i >= 0; i--)  ex_d(100 * i, "t1_decay");
        ex_i("t1_idle");
        @(negedge clk);
        trig = 1'b0; amp = -16'sd5; step = 12'd7; flat_len = 20'd1;
        drain("t1");

        // 2: negative target not a multiple of step
        amp = -16'sd250; step = 12'd100; flat_len = 20'd2; trig = 1'b1;
        ex_r(-100, "t2_ramp"); ex_r(-200, "t2_ramp"); ex_r(-250, "t2_ramp_clamp");
        ex_f(-250, "t2_flat"); ex_f(-250, "t2_flat");
        ex_d(-150, "t2_decay"); ex_d(-50, "t2_decay"); ex_d(0, "t2_decay_clamp");
        ex_i("t2_idle");
        @(negedge clk);
        trig = 1'b0;
        drain("t2");

        // 3: trip during flat-top, trig ignored, clear gated by trip_hit
        trip_level = 15'd500;
        amp = 16'sd1000; step = 12'd500; flat_len = 20'd10; trig = 1'b1;
        ex_r(500, "t3_ramp"); ex_r(1000, "t3_ramp");
        ex_f(1000, "t3_flat"); ex_f(1000, "t3_flat_cav_sampled");
        ex_t("t3_trip_drive0"); ex_t("t3_trig_clear_ignored"); ex_t("t3_trip_hold");
        ex_i("t3_cleared"); ex_i("t3_idle");
        @(negedge clk); trig = 1'b0;
        @(negedge clk);
        @(negedge clk); cav = 16'sd600;
        @(negedge clk);
        @(negedge clk); trig = 1'b1; trip_clear = 1'b1;
        @(negedge clk); trig = 1'b0; trip_clear = 1'b0; cav = 16'sd100;
        @(negedge clk); trip_clear = 1'b1;
        @(negedge clk); trip_clear = 1'b0;
        drain("t3");
        trip_level = 15'd32767; cav = 16'sd0;

        // 4: abort mid-ramp at drive=700
        amp = 16'sd2000; step = 12'd100; flat_len = 20'd3; trig = 1'b1;
        for (int i = 1; i <= 7; i++)  ex_r(100 * i, "t4_ramp");
        for (int i = 6; i >= 0; i--)  ex_d(100 * i, "t4_abort_decay");
        ex_i("t4_idle");
        @(negedge clk); trig = 1'b0;
        repeat (6) @(negedge clk);
        abort = 1'b1;
        drain("t4");
        abort = 1'b0;

        // 5: most negative amp, zero step, zero flat length
        amp = -16'sd32768; step = 12'd0; flat_len = 20'd0; trig = 1'b1;
        ex_r(-32767, "t5_ramp_sat"); ex_d(0, "t5_decay_step0"); ex_i("t5_idle");
        @(negedge clk); trig = 1'b0;
        drain("t5");
        // cav=-32768 against trip_level=32766 trips
        trip_level = 15'd32766; cav = -16'sd32768;
        ex_i("t5_hit_latency"); ex_t("t5_trip_min_cav"); ex_i("t5_cleared");
        @(negedge clk); cav = 16'sd0;
        @(negedge clk); trip_clear = 1'b1;
        @(negedge clk); trip_clear = 1'b0;
        drain("t5_trip");
        // trip_level=32767 never trips
        trip_level = 15'd32767; cav = -16'sd32768;
        ex_i("t5_no_trip"); ex_i("t5_no_trip"); ex_i("t5_no_trip");
        drain("t5_no_trip");
        cav = 16'sd0;

        // 6: reset mid flat-top, trig held in reset ignored, later trig runs
        amp = 16'sd1000; step = 12'd500; flat_len = 20'd10; trig = 1'b1;
        ex_r(500, "t6_ramp"); ex_r(1000, "t6_ramp");
        ex_f(1000, "t6_flat"); ex_f(1000, "t6_flat");
        ex_i("t6_reset"); ex_i("t6_reset_trig_held"); ex_i("t6_after_reset");
        ex_r(500, "t6_restart"); ex_r(1000, "t6_restart");
        for (int i = 0; i < 10; i++) ex_f(1000, "t6_flat2");
        ex_d(500, "t6_decay"); ex_d(0, "t6_decay");
        ex_i("t6_idle");
        @(negedge clk); trig = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); rst = 1'b1; trig = 1'b1;
        @(negedge clk);
        @(negedge clk); rst = 1'b0; trig = 1'b0;
        @(negedge clk); trig = 1'b1;
        @(negedge clk); trig = 1'b0;
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    join_any
  end

endmodule
